iir_cascade_sequencer: RTL and testbench
========================================

// Module: iir_cascade_sequencer
// PURPOSE
//  Scheduler that time-multiplexes one shared biquad engine across NUM_SECTIONS cascaded sections.
//  Accepts one sample per AXIS handshake and issues it to section 0. Each section result is fed back as the next section's input.
//  Presents the final section output on an AXIS master with backpressure.
//  Sits between the ADC sample stream and the ECG output stream. The engine holds per-section coefficients and delay state, indexed by eng_sec.
// PARAMETERS
//  DATA_W        16  sample width, signed two's complement
//  NUM_SECTIONS  2   number of cascaded biquad sections (1..16)
//  SEC_W         4   width of eng_sec; must be >= $clog2(NUM_SECTIONS), min 1
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  s_axis_tdata   in   DATA_W  input sample
//  s_axis_tvalid  in   1       input sample valid
//  s_axis_tready  out  1       sequencer can accept a sample
//  m_axis_tdata   out  DATA_W  filtered sample
//  m_axis_tvalid  out  1       filtered sample valid
//  m_axis_tready  in   1       downstream ready
//  bypass         in   1       1: route samples around the engine (sampled at accept)
//  flush          in   1       request to clear engine state and output register
//  eng_start      out  1       one-cycle pulse: engine consumes eng_x for section eng_sec
//  eng_sec        out  SEC_W   section index for current operation
//  eng_x          out  DATA_W  engine input sample
//  eng_clr        out  1       one-cycle pulse: engine zeroes all section delay state
//  eng_done       in   1       one-cycle pulse: eng_y valid (>=1 cycle after eng_start)
//  eng_y          in   DATA_W  engine result
//  busy           out  1       high in any state other than IDLE
//  err_unexp_done out  1       sticky: eng_done seen outside WAIT; cleared only by rst
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; eng_sec 0; output register empty.
//  Handshakes:
//   - Input accept: s_axis_tvalid & s_axis_tready.
//   - Output accept: m_axis_tvalid & m_axis_tready.
//   - s_axis_tready = (state==IDLE) & ~flush.
//  States:
//   IDLE
//    - flush=1: pulse eng_clr, clear m_axis_tvalid, stay in IDLE. flush has priority over accept.
//    - accept with bypass=1: go to HOLD with result = s_axis_tdata. The engine is untouched.
//    - accept with bypass=0: latch the sample into eng_x, set eng_sec=0, go to ISSUE.
//   ISSUE
//    - Drive eng_start=1 for exactly one cycle.
//    - Go to WAIT.
//   WAIT
//    - Hold eng_sec and eng_x stable until eng_done.
//    - On eng_done, if eng_sec < NUM_SECTIONS-1: set eng_x=eng_y, increment eng_sec, go to ISSUE.
//    - On eng_done, if eng_sec == NUM_SECTIONS-1: result = eng_y, go to HOLD.
//   HOLD
//    - If the output register is empty, or is being accepted this cycle: load the result.
//    - On that load, assert m_axis_tvalid on the next cycle and go to IDLE.
//    - Otherwise stay in HOLD. This is the stall case.
//  Output register:
//   - m_axis_tdata and m_axis_tvalid hold stable until accepted.
//   - On accept with no load in the same cycle, tvalid drops.
//   - The next sample may be accepted while the previous output is still pending. One result is in flight plus one held.
//  Latency:
//   - Engine latency L = cycles from eng_start to eng_done.
//   - Accept at cycle T: eng_start at T+1. Each later section starts at prev_done+1.
//   - With output empty, m_axis_tvalid rises at T+1+N*(L+1)+1.
//   - Bypass: m_axis_tvalid rises at T+2.
//  No arithmetic is done here; samples pass at full DATA_W, unmodified.
//  eng_done outside WAIT is ignored, except that it sets err_unexp_done.
//  Section index wraps never: it resets to 0 at each accept.
//  rst mid-operation: immediately returns to IDLE and drops the in-flight sample. eng_clr is NOT pulsed; the system must pulse flush after reset.
// TESTING
//  1. Impulse, N=2, L=3:
//     - Stimulus: accept 32767 at T.
//     - eng_start at T+1 with sec 0, x=32767; eng_start at T+5 with sec 1, x=section-0 y.
//     - m_axis_tvalid at T+10 with data = section-1 y.
//  2. Backpressure:
//     - Stimulus: hold m_axis_tready=0, send 3 samples.
//     - First result held stable; second waits in HOLD; s_axis_tready stays 0 for the third.
//     - Release tready: results emerge in order, none lost or duplicated.
//  3. Bypass:
//     - Stimulus: bypass=1, send -1234.
//     - m_axis_tdata=-1234 at T+2; eng_start never asserted.
//  4. Flush:
//     - Stimulus: pulse flush in IDLE with an output pending.
//     - One-cycle eng_clr; m_axis_tvalid=0; s_axis_tready=0 during that cycle.
//  5. Reset mid-operation:
//     - Stimulus: assert rst during WAIT.
//     - Outputs 0 asynchronously; after release, next sample starts at sec 0.
//     - Inject a stray eng_done in IDLE -> err_unexp_done=1.
//  6. Sine stream:
//     - Stimulus: 250 noisy 500 kHz samples, one every 5 clk, against a golden biquad-cascade model.
//     - Output bit-exact vs model; count out = 250.

Source files
------------

// File: rtl/iir_cascade_sequencer.sv
// rtl/iir_cascade_sequencer.sv - schedules one shared biquad engine across cascaded sections
module iir_cascade_sequencer #(
   parameter int DATA_W       = 16,
   parameter int NUM_SECTIONS = 2,
   parameter int SEC_W        = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   input  logic              bypass,
   input  logic              flush,
   output logic              eng_start,
   output logic [SEC_W-1:0]  eng_sec,
   output logic [DATA_W-1:0] eng_x,
   output logic              eng_clr,
   input  logic              eng_done,
   input  logic [DATA_W-1:0] eng_y,
   output logic              busy,
   output logic              err_unexp_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NUM_SECTIONS - 1);

   state_t              state_q;
   logic [SEC_W-1:0]    eng_sec_q;
   logic [DATA_W-1:0]   eng_x_q;
   logic                eng_start_q;
   logic                eng_clr_q;
   logic [DATA_W-1:0]   result_q;
   logic [DATA_W-1:0]   m_tdata_q;
   logic                m_tvalid_q;
   logic                err_q;

   logic                in_accept;
   logic                out_accept;
   logic                hold_load;

   // Ready is gated by rst so every output reads 0 while reset is held.
   assign s_axis_tready = (state_q == IDLE) & ~flush & ~rst;
   assign in_accept     = s_axis_tvalid & s_axis_tready;
   assign out_accept    = m_tvalid_q & m_axis_tready;
   // The held result may move into the output register when it is empty or draining this cycle.
   assign hold_load     = (state_q == HOLD) & (~m_tvalid_q | m_axis_tready);

   assign eng_start      = eng_start_q;
   assign eng_sec        = eng_sec_q;
   assign eng_x          = eng_x_q;
   assign eng_clr        = eng_clr_q;
   assign m_axis_tdata   = m_tdata_q;
   assign m_axis_tvalid  = m_tvalid_q;
   assign busy           = (state_q != IDLE);
   assign err_unexp_done = err_q;

   // Sequencer FSM with registered engine strobes and the output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         eng_sec_q   <= '0;
         eng_x_q     <= '0;
         eng_start_q <= 1'b0;
         eng_clr_q   <= 1'b0;
         result_q    <= '0;
         m_tdata_q   <= '0;
         m_tvalid_q  <= 1'b0;
      end else begin
         eng_start_q <= 1'b0;
         eng_clr_q   <= 1'b0;
         if (out_accept) begin
            m_tvalid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (flush) begin
                  eng_clr_q  <= 1'b1;
                  m_tvalid_q <= 1'b0;
               end else if (in_accept) begin
                  if (bypass) begin
                     result_q <= s_axis_tdata;
                     state_q  <= HOLD;
                  end else begin
                     eng_x_q     <= s_axis_tdata;
                     eng_sec_q   <= '0;
                     eng_start_q <= 1'b1;
                     state_q     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (eng_done) begin
                  if (eng_sec_q == LAST_SEC) begin
                     result_q <= eng_y;
                     state_q  <= HOLD;
                  end else begin
                     eng_x_q     <= eng_y;
                     eng_sec_q   <= eng_sec_q + SEC_W'(1);
                     eng_start_q <= 1'b1;
                     state_q     <= ISSUE;
                  end
               end
            end
            HOLD: begin
               if (hold_load) begin
                  m_tdata_q  <= result_q;
                  m_tvalid_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Sticky flag for an engine completion arriving while no operation is outstanding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (eng_done && (state_q != WAIT)) begin
         err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_iir_cascade_sequencer.sv
// tb/tb_iir_cascade_sequencer.sv - randomized self-checking bench with biquad cascade model
module tb_iir_cascade_sequencer;

   localparam int DW = 16;
   localparam int NS = 2;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s_tdata;
   logic          s_tvalid;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic          bypass;
   logic          flush;
   logic          eng_start;
   logic [SW-1:0] eng_sec;
   logic [DW-1:0] eng_x;
   logic          eng_clr;
   logic          eng_done;
   logic [DW-1:0] eng_y;
   logic          busy;
   logic          err;

   logic          eng_done_m;
   logic          stray_done;
   logic          rand_mode;
   logic          rnd_rdy;
   logic          man_rdy;

   assign eng_done = eng_done_m | stray_done;
   assign m_tready = rand_mode ? rnd_rdy : man_rdy;

   iir_cascade_sequencer #(.DATA_W(DW), .NUM_SECTIONS(NS), .SEC_W(SW)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .bypass(bypass), .flush(flush),
      .eng_start(eng_start), .eng_sec(eng_sec), .eng_x(eng_x), .eng_clr(eng_clr),
      .eng_done(eng_done), .eng_y(eng_y),
      .busy(busy), .err_unexp_done(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;
   int n_starts = 0;
   int lat_fixed = 3;
   int exp_q[$];

   // Biquad coefficients in Q14, direct form I; set 0 = engine, set 1 = reference model.
   int B0[NS] = '{4096, 8192};
   int B1[NS] = '{8192, 0};
   int B2[NS] = '{4096, -8192};
   int A1[NS] = '{-8192, -4096};
   int A2[NS] = '{2048, 4096};
   int st[2][NS][4];

   function automatic int bq(input int set, input int sec, input int x);
      longint acc;
      int y;
      acc = longint'(B0[sec]) * x + longint'(B1[sec]) * st[set][sec][0]
          + longint'(B2[sec]) * st[set][sec][1] - longint'(A1[sec]) * st[set][sec][2]
          - longint'(A2[sec]) * st[set][sec][3];
      acc = acc >>> 14;
      if (acc > 32767) y = 32767;
      else if (acc < -32768) y = -32768;
      else y = int'(acc);
      st[set][sec][1] = st[set][sec][0];
      st[set][sec][0] = x;
      st[set][sec][3] = st[set][sec][2];
      st[set][sec][2] = y;
      return y;
   endfunction

   function automatic void clear_state(input int set);
      for (int s = 0; s < NS; s++)
         for (int k = 0; k < 4; k++)
            st[set][s][k] = 0;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Engine model: consumes start, returns the biquad result after L cycles, aborts on reset.
   initial begin
      int sec, x, y, lat, last_y, last_sec;
      bit aborted;
      eng_done_m = 1'b0;
      eng_y = '0;
      last_y = 0;
      last_sec = 0;
      forever begin
         @(negedge clk);
         if (eng_start && !rst) begin
            sec = int'(eng_sec);
            x = int'($signed(eng_x));
            if (sec != 0) begin
               chk("eng_sec_step", sec, last_sec + 1);
               chk("eng_x_chain", x, last_y);
            end
            y = bq(0, sec, x);
            lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
            aborted = 0;
            repeat (lat) begin
               @(posedge clk);
               if (rst) aborted = 1;
            end
            if (!aborted) begin
               #1;
               eng_done_m = 1'b1;
               eng_y = DW'(y);
               last_y = y;
               last_sec = sec;
               @(posedge clk);
               #1;
               eng_done_m = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) if (eng_clr) clear_state(0);

   initial begin
      rnd_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rnd_rdy = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: model expectations at input accept, compare at output accept, output hold stability.
   initial begin
      int v;
      logic pv, pr, pf;
      logic [DW-1:0] pd;
      pv = 0; pr = 0; pf = 0; pd = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 0;
         end else begin
            if (s_tvalid && s_tready) begin
               v = int'($signed(s_tdata));
               if (!bypass)
                  for (int s = 0; s < NS; s++) v = bq(1, s, v);
               exp_q.push_back(v);
            end
            if (eng_start) n_starts++;
            if (pv && !pr && !pf) begin
               n_tests++;
               if (!(m_tvalid && m_tdata == pd)) begin
                  n_fail++;
                  $display("FAIL out_hold: got v=%0b d=%0d expected v=1 d=%0d", m_tvalid, $signed(m_tdata), $signed(pd));
               end
            end
            if (m_tvalid && m_tready) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  chk("out_unexpected", 1, 0);
               end else begin
                  chk("out_data", int'($signed(m_tdata)), exp_q.pop_front());
               end
            end
            pv = m_tvalid; pr = m_tready; pd = m_tdata; pf = flush;
         end
      end
   end

   task automatic send(input int d, input logic byp, output int t);
      int n;
      @(posedge clk);
      #1;
      s_tdata = DW'(d);
      s_tvalid = 1'b1;
      bypass = byp;
      n = 0;
      t = -1;
      while (n < 300) begin
         @(negedge clk);
         if (s_tready) begin
            t = cyc;
            break;
         end
         n++;
      end
      if (t < 0) chk("send_timeout", 1, 0);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      bypass = 1'b0;
   endtask

   task automatic do_flush();
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_tready", s_tready, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      exp_q.delete();
      clear_state(1);
      @(negedge clk);
      chk("flush_clr_tvalid", {eng_clr, m_tvalid}, 2'b10);
      @(negedge clk);
      chk("flush_clr_pulse", eng_clr, 0);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy || m_tvalid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      int t0, tv_cyc, n0, n, k, val;
      int sc[2], ss[2], sx[2], ns;
      logic [DW-1:0] tv_d;
      bit blocked;
      rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; bypass = 1'b0; flush = 1'b0;
      man_rdy = 1'b1; rand_mode = 1'b0; stray_done = 1'b0;
      clear_state(0);
      clear_state(1);
      #12;
      chk("reset_outputs", {s_tready, m_tvalid, m_tdata, eng_start, eng_sec, eng_x, eng_clr, busy, err}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", s_tready, 1);
      do_flush();

      // Impulse with fixed latency 3: hand-computed section outputs 8191 then 4095.
      lat_fixed = 3;
      send(32767, 1'b0, t0);
      ns = 0; tv_cyc = -1; tv_d = '0;
      repeat (15) begin
         @(negedge clk);
         if (eng_start && ns < 2) begin
            sc[ns] = cyc; ss[ns] = int'(eng_sec); sx[ns] = int'($signed(eng_x)); ns++;
         end
         if (m_tvalid && tv_cyc < 0) begin
            tv_cyc = cyc; tv_d = m_tdata;
         end
      end
      chk("imp_nstarts", ns, 2);
      if (ns == 2) begin
         chk("imp_start0_cyc", sc[0] - t0, 1);
         chk("imp_start0_sec_x", {ss[0], sx[0]}, {32'd0, 32'd32767});
         chk("imp_start1_cyc", sc[1] - t0, 5);
         chk("imp_start1_sec_x", {ss[1], sx[1]}, {32'd1, 32'd8191});
      end
      chk("imp_tvalid_cyc", tv_cyc - t0, 10);
      chk("imp_tdata", int'($signed(tv_d)), 4095);

      // Bypass: -1234 straight through at T+2, engine untouched.
      n0 = n_starts;
      send(-1234, 1'b1, t0);
      tv_cyc = -1;
      repeat (8) begin
         @(negedge clk);
         if (m_tvalid && tv_cyc < 0) begin
            tv_cyc = cyc; tv_d = m_tdata;
         end
      end
      chk("byp_tvalid_cyc", tv_cyc - t0, 2);
      chk("byp_tdata", int'($signed(tv_d)), -1234);
      chk("byp_no_start", n_starts - n0, 0);

      // Backpressure: two results stall, third input blocked, then drain in order.
      lat_fixed = 2;
      man_rdy = 1'b0;
      n0 = n_out;
      send(1000, 1'b0, t0);
      send(-2000, 1'b0, t0);
      repeat (15) @(negedge clk);
      @(posedge clk);
      #1;
      s_tdata = DW'(3000); s_tvalid = 1'b1;
      blocked = 1;
      repeat (10) begin
         @(negedge clk);
         if (s_tready) blocked = 0;
      end
      chk("bp_third_blocked", blocked, 1);
      chk("bp_busy_hold", {busy, m_tvalid}, 2'b11);
      if (exp_q.size() > 0) chk("bp_first_held", int'($signed(m_tdata)), exp_q[0]);
      @(posedge clk);
      #1;
      man_rdy = 1'b1;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (s_tready) break;
         n++;
      end
      chk("bp_third_accept", n < 200, 1);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      wait_drain();
      chk("bp_out_count", n_out - n0, 3);

      // Flush with an output pending.
      man_rdy = 1'b0;
      send(777, 1'b0, t0);
      n = 0;
      while (!m_tvalid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("flush_pending", m_tvalid, 1);
      do_flush();
      repeat (3) @(negedge clk);
      chk("flush_stays_empty", m_tvalid, 0);
      man_rdy = 1'b1;

      // Reset during WAIT, then restart from section 0 and catch a stray done.
      lat_fixed = 3;
      send(5555, 1'b0, t0);
      @(negedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_async_outputs", {s_tready, m_tvalid, eng_start, eng_sec, eng_x, eng_clr, busy}, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      do_flush();
      chk("err_clear", err, 0);
      send(321, 1'b0, t0);
      @(negedge clk);
      chk("restart_sec0", {eng_start, eng_sec}, {1'b1, 4'd0});
      wait_drain();
      @(posedge clk);
      #1;
      stray_done = 1'b1;
      @(posedge clk);
      #1;
      stray_done = 1'b0;
      @(negedge clk);
      chk("err_stray_done", err, 1);
      do_flush();
      chk("err_sticky", err, 1);

      // Noisy sine stream with random engine latency and random downstream ready.
      lat_fixed = 0;
      #1;
      rand_mode = 1'b1;
      n0 = n_out;
      for (k = 0; k < 250; k++) begin
         val = $rtoi(12000.0 * $sin(6.283185307 * k / 40.0)) + int'($urandom_range(0, 2000)) - 1000;
         send(val, 1'b0, t0);
         repeat (4) @(posedge clk);
         #1;
      end
      rand_mode = 1'b0;
      wait_drain();
      chk("stream_count", n_out - n0, 250);

      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("err_cleared_by_rst", err, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

endmodule
